// File: rtl/motor_pwm_mixer_if.sv
// Command/drive bundle between the PID stage, the PWM mixer and the motor pins.
// The master drives the run request and commands. The slave drives the pin, duty and status signals.
interface motor_pwm_mixer_if;
  logic        enable;
  logic [10:0] pid_output;
  logic [10:0] base_speed;
  logic        pwm_left;
  logic        pwm_right;
  logic [10:0] duty_left;
  logic [10:0] duty_right;
  logic        period_start;
  logic        busy;
  logic [1:0]  state;

  modport master (
    output enable, pid_output, base_speed,
    input  pwm_left, pwm_right, duty_left, duty_right, period_start, busy, state
  );

  modport slave (
    input  enable, pid_output, base_speed,
    output pwm_left, pwm_right, duty_left, duty_right, period_start, busy, state
  );
endinterface

// File: rtl/motor_pwm_mixer.sv
// Differential-drive PWM mixer: samples the steering command once per PWM period and slews both wheel duties.
// MOTOR_RAMP_EN enables per-period slew limiting. Without it, duties jump straight to their goals.
module motor_pwm_mixer #(
  parameter int PRESCALE  = 100,
  parameter int RAMP_STEP = 10
) (
  input  logic             clk,
  input  logic             rst,
  motor_pwm_mixer_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOPPING = 2'd2} state_t;

`ifdef MOTOR_RAMP_EN
  localparam bit RAMP_EN = 1'b1;
`else
  localparam bit RAMP_EN = 1'b0;
`endif
  // A step of 1000 covers any possible gap, so the unramped build reaches its goal in one update.
  localparam logic [10:0] STEP = RAMP_EN ? 11'(RAMP_STEP) : 11'd1000;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] pre_cnt_q;
  logic [9:0]    tick_q;
  state_t        state_q, state_d;
  logic [10:0]   duty_l_q, duty_l_d, duty_r_q, duty_r_d;
  logic          pwm_l_q, pwm_r_q, pstart_q;

  logic               pre_wrap, pe;
  logic [10:0]        cmd, base, tgt_l, tgt_r;
  logic signed [11:0] steer, sum_l, sum_r;

  function automatic logic [10:0] slew(input logic [10:0] cur, input logic [10:0] goal);
    if (goal > cur) return (goal - cur > STEP) ? cur + STEP : goal;
    else            return (cur - goal > STEP) ? cur - STEP : goal;
  endfunction

  always_comb begin
    pre_wrap = (pre_cnt_q == PW'(PRESCALE - 1));
    pe       = pre_wrap && (tick_q == 10'd999);

    cmd   = (bus.pid_output > 11'd1000) ? 11'd1000 : bus.pid_output;
    base  = (bus.base_speed > 11'd1000) ? 11'd1000 : bus.base_speed;
    steer = $signed({1'b0, cmd}) - 12'sd500;
    sum_l = $signed({1'b0, base}) + steer;
    sum_r = $signed({1'b0, base}) - steer;

    if (sum_l < 12'sd0)         tgt_l = 11'd0;
    else if (sum_l > 12'sd1000) tgt_l = 11'd1000;
    else                        tgt_l = sum_l[10:0];
    if (sum_r < 12'sd0)         tgt_r = 11'd0;
    else if (sum_r > 12'sd1000) tgt_r = 11'd1000;
    else                        tgt_r = sum_r[10:0];
  end

  // The goal comes from the state that was active during the period that is ending.
  always_comb begin
    state_d  = state_q;
    duty_l_d = duty_l_q;
    duty_r_d = duty_r_q;
    if (pe) begin
      case (state_q)
        IDLE: begin
          duty_l_d = 11'd0;
          duty_r_d = 11'd0;
          if (bus.enable) state_d = RUN;
        end
        RUN: begin
          duty_l_d = slew(duty_l_q, tgt_l);
          duty_r_d = slew(duty_r_q, tgt_r);
          if (!bus.enable) state_d = STOPPING;
        end
        STOPPING: begin
          duty_l_d = slew(duty_l_q, 11'd0);
          duty_r_d = slew(duty_r_q, 11'd0);
          if (bus.enable)                                     state_d = RUN;
          else if (duty_l_d == 11'd0 && duty_r_d == 11'd0)    state_d = IDLE;
        end
        default: begin
          state_d  = IDLE;
          duty_l_d = 11'd0;
          duty_r_d = 11'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt_q <= '0;
      tick_q    <= '0;
      state_q   <= IDLE;
      duty_l_q  <= '0;
      duty_r_q  <= '0;
      pwm_l_q   <= 1'b0;
      pwm_r_q   <= 1'b0;
      pstart_q  <= 1'b0;
    end else begin
      pre_cnt_q <= pre_wrap ? '0 : pre_cnt_q + PW'(1);
      if (pre_wrap) tick_q <= (tick_q == 10'd999) ? 10'd0 : tick_q + 10'd1;
      state_q   <= state_d;
      duty_l_q  <= duty_l_d;
      duty_r_q  <= duty_r_d;
      pwm_l_q   <= (state_q != IDLE) && ({1'b0, tick_q} < duty_l_q);
      pwm_r_q   <= (state_q != IDLE) && ({1'b0, tick_q} < duty_r_q);
      pstart_q  <= pe;
    end
  end

  assign bus.pwm_left     = pwm_l_q;
  assign bus.pwm_right    = pwm_r_q;
  assign bus.duty_left    = duty_l_q;
  assign bus.duty_right   = duty_r_q;
  assign bus.period_start = pstart_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.state        = state_q;
endmodule
